// File: rtl/bram16_copy_dma_pkg.sv
// Shared definitions for the bram16 copy/fill DMA initiator.
// Holds the FSM state encoding, the mode values and the address step.
// Imported by the DMA top and by anything that needs to decode its state.
package bram16_copy_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  // Byte step between consecutive 16-bit words on the bus.
  localparam int ADDR_STEP = 2;

  // The pointers count words, so one bus step is one word-pointer increment.
  localparam logic [14:0] WORD_STEP = 15'(ADDR_STEP / 2);

  // Word pointer to bus byte address; bit 0 is always driven low.
  function automatic logic [15:0] bus_addr(input logic [14:0] wptr);
    return {wptr, 1'b0};
  endfunction

endpackage

// File: rtl/bram16_copy_dma.sv
// Copy/fill DMA initiator for the 16-bit on-chip memory bus (do/di/we/a).
// Latency: first bus cycle one clock after start; copy 2 cycles/word, fill 1 cycle/word.
// No backpressure: target is fixed-latency; start while busy is dropped, abort stops at once.
module bram16_copy_dma
  import bram16_copy_dma_pkg::*;
#(
  parameter int len_width = 10
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 start,
  input  logic                 mode,
  input  logic [15:0]          src,
  input  logic [15:0]          dst,
  input  logic [len_width-1:0] len,
  input  logic [15:0]          pattern,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          dout,
  input  logic [15:0]          di,
  output logic                 we,
  output logic [15:0]          a
);

  state_t                 state_q, state_d;
  logic [14:0]            src_ptr_q, src_ptr_d;
  logic [14:0]            dst_ptr_q, dst_ptr_d;
  logic [len_width-1:0]   rem_q, rem_d;
  logic                   mode_q, mode_d;
  logic [15:0]            pattern_q, pattern_d;

  // Byte-address LSBs are ignored by targets, so only the word part is kept.
  logic unused_addr_lsb;
  assign unused_addr_lsb = src[0] ^ dst[0];

  // State and datapath registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= ST_IDLE;
      src_ptr_q <= '0;
      dst_ptr_q <= '0;
      rem_q     <= '0;
      mode_q    <= MODE_COPY;
      pattern_q <= '0;
    end else begin
      state_q   <= state_d;
      src_ptr_q <= src_ptr_d;
      dst_ptr_q <= dst_ptr_d;
      rem_q     <= rem_d;
      mode_q    <= mode_d;
      pattern_q <= pattern_d;
    end
  end

  // Next-state logic; abort in RD/WR takes priority over the end-of-block test.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len == '0)              state_d = ST_FIN;
          else if (mode == MODE_FILL) state_d = ST_WR;
          else                        state_d = ST_RD;
        end
      end
      ST_RD: begin
        state_d = abort ? ST_IDLE : ST_WR;
      end
      ST_WR: begin
        if (abort)                        state_d = ST_IDLE;
        else if (rem_q == len_width'(1))  state_d = ST_FIN;
        else if (mode_q == MODE_FILL)     state_d = ST_WR;
        else                              state_d = ST_RD;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: latch the request in IDLE, advance pointers after each write.
  always_comb begin
    src_ptr_d = src_ptr_q;
    dst_ptr_d = dst_ptr_q;
    rem_d     = rem_q;
    mode_d    = mode_q;
    pattern_d = pattern_q;
    if (state_q == ST_IDLE && start) begin
      src_ptr_d = src[15:1];
      dst_ptr_d = dst[15:1];
      rem_d     = len;
      mode_d    = mode;
      pattern_d = pattern;
    end else if (state_q == ST_WR && !abort) begin
      // Pointers wrap silently at the top of the 64 KiB space.
      src_ptr_d = src_ptr_q + WORD_STEP;
      dst_ptr_d = dst_ptr_q + WORD_STEP;
      rem_d     = rem_q - len_width'(1);
    end
  end

  // Bus and status outputs decoded from the current state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    we   = 1'b0;
    a    = '0;
    dout = '0;
    case (state_q)
      ST_RD: begin
        busy = 1'b1;
        a    = bus_addr(src_ptr_q);
      end
      ST_WR: begin
        busy = 1'b1;
        we   = 1'b1;
        a    = bus_addr(dst_ptr_q);
        // In copy mode di carries the word addressed during the preceding RD.
        dout = (mode_q == MODE_FILL) ? pattern_q : di;
      end
      ST_FIN:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bram16_copy_dma.sv
// Testbench: bram16_copy_dma paired with a registered-read 2048-word bram16 target.
module tb_bram16_copy_dma;

  localparam int LW    = 10;
  localparam int WORDS = 2048;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          start = 1'b0, mode = 1'b0, abort = 1'b0;
  logic [15:0]   src = '0, dst = '0, pattern = '0;
  logic [LW-1:0] len = '0;
  logic          busy, done, we;
  logic [15:0]   dout, di, a;

  always #5 sys_clk = ~sys_clk;

  bram16_copy_dma #(.len_width(LW)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .mode(mode),
    .src(src), .dst(dst), .len(len), .pattern(pattern), .abort(abort),
    .busy(busy), .done(done), .dout(dout), .di(di), .we(we), .a(a)
  );

  // bram16 target (adr_width=11): registered read, write on we; a preload port for the bench.
  logic [15:0] mem [WORDS];
  logic        pre_we = 1'b0;
  logic [10:0] pre_idx = '0;
  logic [15:0] pre_dat = '0;
  always @(posedge sys_clk) begin
    if (pre_we)  mem[pre_idx] <= pre_dat;
    else if (we) mem[a[11:1]] <= dout;
    di <= mem[a[11:1]];
  end

  // Reference memory image, updated by applying whole transfers word by word.
  logic [15:0] ref_mem [WORDS];
  int pass_cnt = 0, fail_cnt = 0, total_cnt = 0;
  logic [15:0] wr_addrs [$];

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [15:0] val);
    pre_we = 1'b1; pre_idx = 11'(idx); pre_dat = val;
    ref_mem[idx] = val;
    tick();
    pre_we = 1'b0;
  endtask

  // Effect of n completed word writes of a transfer, in ascending order.
  function automatic void ref_xfer(input logic m, input logic [15:0] s, input logic [15:0] d,
                                   input logic [15:0] p, input int n);
    int sw = int'(s[11:1]);
    int dw = int'(d[11:1]);
    for (int i = 0; i < n; i++)
      ref_mem[(dw + i) % WORDS] = m ? p : ref_mem[(sw + i) % WORDS];
  endfunction

  task automatic check_mem(input string tag);
    int bad = 0;
    for (int i = 0; i < WORDS; i++) if (mem[i] !== ref_mem[i]) bad++;
    check(tag, 32'(bad), 32'd0);
  endtask

  // One complete transfer with expectations derived from mode/len alone.
  task automatic run_xfer(input string tag, input logic m, input logic [15:0] s,
                          input logic [15:0] d, input int l, input logic [15:0] p,
                          input int inject_at, input logic abort_with_start);
    int busy_n = 0, done_n = 0;
    logic [15:0] first_a, exp_first;
    wr_addrs.delete();
    mode = m; src = s; dst = d; len = LW'(l); pattern = p;
    start = 1'b1; abort = abort_with_start;
    tick();
    start = 1'b0; abort = 1'b0;
    first_a = a;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (busy) busy_n++;
      if (we) wr_addrs.push_back(a);
      if (done) begin done_n++; break; end
      if (cyc == inject_at) begin
        start = 1'b1; len = LW'(1); dst = 16'h0F00; mode = ~m;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    exp_first = (l == 0) ? 16'h0 : (m ? {d[15:1], 1'b0} : {s[15:1], 1'b0});
    check({tag, "_first_a"}, 32'(first_a), 32'(exp_first));
    check({tag, "_done"}, 32'(done_n), 32'd1);
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'(m ? l : 2 * l));
    check({tag, "_writes"}, 32'(wr_addrs.size()), 32'(l));
    for (int i = 0; i < l && i < wr_addrs.size(); i++)
      check({tag, "_wr_addr"}, 32'(wr_addrs[i]), 32'(16'({d[15:1], 1'b0} + 16'(2 * i))));
    tick();
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    ref_xfer(m, s, d, p, l);
    check_mem({tag, "_mem"});
  endtask

  initial begin
    logic [15:0] ps, pd, pp;
    int pl;
    // Reset state.
    tick(); tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_we",   32'(we),   32'd0);
    check("rst_a",    32'(a),    32'd0);
    check("rst_do",   32'(dout), 32'd0);
    sys_rst = 1'b0;
    for (int i = 0; i < WORDS; i++) preload(i, 16'($urandom));

    // Directed copy of 1..4 from 0x0000 to 0x0100.
    for (int i = 0; i < 4; i++) preload(i, 16'(i + 1));
    run_xfer("copy4", 1'b0, 16'h0000, 16'h0100, 4, 16'h0, -1, 1'b0);
    for (int i = 0; i < 4; i++) check("copy4_word", 32'(mem[16'h0080 + i]), 32'(i + 1));

    // Fill 3 words at 0x0200.
    run_xfer("fill3", 1'b1, 16'h0000, 16'h0200, 3, 16'hA5A5, -1, 1'b0);
    check("fill3_word", 32'(mem[16'h0102]), 32'h0000A5A5);

    // Zero-length copy.
    run_xfer("len0", 1'b0, 16'h0000, 16'h0300, 0, 16'h0, -1, 1'b0);

    // Odd byte addresses drive bit 0 low.
    run_xfer("odd", 1'b0, 16'h0011, 16'h0021, 1, 16'h0, -1, 1'b0);

    // Start while busy must not relatch (len stays 6).
    run_xfer("busy_start", 1'b0, 16'h0040, 16'h0340, 6, 16'h0, 3, 1'b0);

    // Abort during the third write cycle of a 4-word fill: that write completes.
    mode = 1'b1; dst = 16'h0400; len = LW'(4); pattern = 16'h5A3C;
    start = 1'b1; tick(); start = 1'b0;
    check("abort_w1", 32'(we), 32'd1);
    tick();
    check("abort_w2", 32'(we), 32'd1);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    ref_xfer(1'b1, 16'h0, 16'h0400, 16'h5A3C, 3);
    // Start in the very next cycle, with abort also high: start wins.
    run_xfer("after_abort", 1'b1, 16'h0000, 16'h0410, 2, 16'h1234, -1, 1'b1);

    // Randomized copies and fills, including overlapping copies.
    for (int t = 0; t < 10; t++) begin
      ps = 16'($urandom_range(0, 1900) * 2 + $urandom_range(0, 1));
      pd = (t % 3 == 0) ? 16'(ps + 16'($urandom_range(2, 20)))
                        : 16'($urandom_range(0, 1900) * 2 + $urandom_range(0, 1));
      pl = $urandom_range(0, 40);
      pp = 16'($urandom);
      run_xfer("rand", 1'($urandom_range(0, 1)), ps, pd, pl, pp, -1, 1'b0);
    end

    // Synchronous reset in WR: bus goes quiet next cycle, partial data stays.
    mode = 1'b1; dst = 16'h0600; len = LW'(5); pattern = 16'hBEEF;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    sys_rst = 1'b1;
    tick();
    check("rstwr_we",   32'(we),   32'd0);
    check("rstwr_a",    32'(a),    32'd0);
    check("rstwr_busy", 32'(busy), 32'd0);
    check("rstwr_done", 32'(done), 32'd0);
    sys_rst = 1'b0;
    tick(); tick();
    check("rstwr_no_done", 32'(done), 32'd0);
    ref_xfer(1'b1, 16'h0, 16'h0600, 16'hBEEF, 2);
    check_mem("rstwr_mem");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
